// File: rtl/mul_arbiter.sv
// Round-robin arbiter that time-shares one signed 4x4 multiplier among N_REQ
// requesters and returns the upper product nibble tagged with the requester ID.

module multiplier (
  input  logic signed [3:0] A,
  input  logic signed [3:0] B,
  output logic signed [7:0] y
);
  logic signed [7:0] a_ext;
  logic signed [7:0] b_ext;

  assign a_ext = {{4{A[3]}}, A};
  assign b_ext = {{4{B[3]}}, B};
  assign y     = a_ext * b_ext;
endmodule

module mul_arbiter #(
  parameter  int N_REQ = 2,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [4*N_REQ-1:0] req_a,
  input  logic [4*N_REQ-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [3:0]         rsp_y,
  output logic [ID_W-1:0]    rsp_id
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_id;
  logic            win_any;
  logic [ID_W-1:0] op_id;
  logic [3:0]      op_a;
  logic [3:0]      op_b;
  logic [7:0]      product;

  multiplier u_mul (
    .A (op_a),
    .B (op_b),
    .y (product)
  );

  // Scan from the highest offset down so the last hit is the first requester
  // at or after rr_ptr; this avoids a break and keeps the search unrolled.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    win_any = 1'b0;
    win_id  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        win_any = 1'b1;
        win_id  = ID_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !reset && win_any) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_any)   state_nxt = CALC;
      CALC:                   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= '0;
    end else begin
      unique case (state)
        IDLE: if (win_any) begin
          op_a   <= req_a[4*int'(win_id) +: 4];
          op_b   <= req_b[4*int'(win_id) +: 4];
          op_id  <= win_id;
          rr_ptr <= ID_W'((int'(win_id) + 1) % N_REQ);
        end
        CALC: begin
          rsp_y     <= product[7:4];
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one instance of the team's combinational 4-bit signed `multiplier` among N_REQ requesters. Each requester issues operands over a valid/ready handshake. The block registers the operands, lets the multiplier evaluate, and returns the upper nibble of the signed product over a valid/ready response channel tagged with the requester ID. One transaction is outstanding at a time.

Parameters:
N_REQ, 2, number of requesters; legal range 2..8
ID_W, $clog2(N_REQ), width of the requester ID; derived, do not override

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  N_REQ  bit i: requester i presents operands
req_ready  output  N_REQ  bit i: requester i's operands are accepted this cycle (one-hot or zero)
req_a  input  4*N_REQ  requester i operand A, signed, at bits [4i+3:4i]
req_b  input  4*N_REQ  requester i operand B, signed, at bits [4i+3:4i]
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts the response
rsp_y  output  4  bits [7:4] of the signed 8-bit product A*B
rsp_id  output  ID_W  index of the requester the response belongs to

Behaviour:
- FSM states: IDLE, CALC, RESP.
- Reset (synchronous, takes effect at the edge where reset=1):
  - state=IDLE, rr_ptr=0, rsp_valid=0, rsp_y=0, rsp_id=0.
  - Operand registers are cleared to 0.
  - req_ready=0 while reset is high.
  - An in-flight transaction is discarded with no response.
- IDLE:
  - req_ready is combinational: one-hot on the winner when any req_valid is set, else all zero.
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - On an accept edge (req_valid[w] & req_ready[w]): latch req_a/req_b slice w and id=w, set rr_ptr=(w+1) mod N_REQ, go to CALC.
  - No request: stay in IDLE; rr_ptr unchanged.
- CALC:
  - req_ready=0.
  - The latched operands drive the multiplier. At the edge, rsp_y <= multiplier output, rsp_id <= latched id, rsp_valid <= 1, go to RESP.
- RESP:
  - req_ready=0; rsp_valid=1.
  - rsp_y and rsp_id hold stable until rsp_valid & rsp_ready.
  - On handshake: rsp_valid <= 0, go to IDLE. rsp_y and rsp_id keep their last value.
- Latency and throughput:
  - Accept at edge T; rsp_valid high from edge T+1, i.e. visible in the cycle after CALC.
  - Accept in cycle k → CALC in cycle k+1 → RESP from cycle k+2.
  - Minimum 3 cycles per transaction: the IDLE cycle after a response is mandatory.
- Arithmetic:
  - 4-bit two's-complement operands; full product is 8-bit signed; output is product[7:4]. Example: -6*3 = -18 = 8'b11101110 → 4'b1110.
  - The multiplier is instantiated, never re-implemented, with ports A, B, y.
- Requester protocol:
  - A requester holds req_valid and its operands stable until accepted.
  - Bits of req_valid that are not granted are ignored; the block does not sample them.
  - req_valid toggling in CALC/RESP has no effect.
- Boundary conditions:
  - All requesters valid: strict rotation.
  - Only one requester valid: it wins regardless of rr_ptr.
  - rr_ptr wraps from N_REQ-1 to 0.
  - rsp_ready high in IDLE/CALC is ignored.
  - Reset asserted in the same cycle as an accept or response handshake: reset wins.

Test Plan:
1. N_REQ=2. After reset, req0 A=0011 B=0011 → req_ready=01 in that cycle; two cycles later rsp_valid=1, rsp_y=0000, rsp_id=0. Hold rsp_ready=1 → back to IDLE.
2. req1 only, A=1010 B=0011 → rsp_y=1110, rsp_id=1 (rr_ptr=0, yet req1 wins).
3. From reset, req0 (A=1111 B=0111) and req1 (A=1000 B=0111) valid together:
   - first response id=0, y=1111;
   - second response id=1, y=1100;
   - req1 accepted in the IDLE cycle right after the first handshake.
4. Both requesters held valid for 4 transactions → response ids 0,1,0,1; never two req_ready bits high.
5. Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_y, rsp_id stable; req_ready=00 throughout. Release → IDLE next cycle.
6. Reset during CALC (req0 A=0010 B=0101 accepted) → next cycle rsp_valid=0, state IDLE, no response ever emitted. rr_ptr=0, so a subsequent simultaneous req0/req1 grants req0.
